// File: rtl/intl_ext_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : intl_ext_filter_if
// Purpose  : Signal bundle between the external interlock filter and its
//            controller/consumer (configuration, raw pins, filtered results).
// Revision : 1.0 - initial release
// ============================================================================
interface intl_ext_filter_if #(
    parameter int NUM_CH    = 16,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 4
);
    logic [NUM_CH-1:0]    i_intl_ext_raw;
    logic [NUM_CH-1:0]    i_polarity;
    logic [NUM_CH-1:0]    i_bypass;
    logic [CNT_WIDTH-1:0] i_filt_len;
    logic                 i_intl_clr;
    logic [NUM_CH-1:0]    o_intl_ext;
    logic [NUM_CH-1:0]    o_rise_pulse;
    logic [NUM_CH-1:0]    o_fall_pulse;
    logic [NUM_CH-1:0]    o_intl_latch;
    logic                 o_intl_any;
    logic                 o_first_valid;
    logic [IDX_WIDTH-1:0] o_first_idx;

    modport master (
        output i_intl_ext_raw, i_polarity, i_bypass, i_filt_len, i_intl_clr,
        input  o_intl_ext, o_rise_pulse, o_fall_pulse, o_intl_latch,
               o_intl_any, o_first_valid, o_first_idx
    );

    modport slave (
        input  i_intl_ext_raw, i_polarity, i_bypass, i_filt_len, i_intl_clr,
        output o_intl_ext, o_rise_pulse, o_fall_pulse, o_intl_latch,
               o_intl_any, o_first_valid, o_first_idx
    );
endinterface
`default_nettype wire

// File: rtl/intl_ext_filter.sv
`default_nettype none
// ============================================================================
// Module   : intl_ext_filter
// Purpose  : Synchronise, polarise and debounce external interlock pins; emit
//            edge pulses, sticky fault latches and a first-fault index.
// Revision : 1.0 - initial release
// ============================================================================
module intl_ext_filter #(
    parameter int NUM_CH    = 16,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    intl_ext_filter_if.slave   bus
);

    logic [NUM_CH-1:0]    r_sync1;
    logic [NUM_CH-1:0]    r_sync2;
    logic [NUM_CH-1:0]    r_filt;
    logic [NUM_CH-1:0]    r_rise;
    logic [NUM_CH-1:0]    r_fall;
    logic [NUM_CH-1:0]    r_latch;
    logic                 r_any;
    logic                 r_first_valid;
    logic [IDX_WIDTH-1:0] r_first_idx;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_CH];

    logic [NUM_CH-1:0]    w_s;
    logic [NUM_CH-1:0]    w_f_next;
    logic [NUM_CH-1:0]    w_latch_next;
    logic [CNT_WIDTH-1:0] w_len_m1;
    logic [IDX_WIDTH-1:0] w_low_idx;

    // Loading polarity into the synchroniser makes the polarised level idle at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= bus.i_polarity;
            r_sync2 <= bus.i_polarity;
        end else begin
            r_sync1 <= bus.i_intl_ext_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s      = r_sync2 ^ bus.i_polarity;
    assign w_len_m1 = (bus.i_filt_len == '0) ? '0 : bus.i_filt_len - CNT_WIDTH'(1);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_f_next[i] = ((w_s[i] != r_filt[i]) && (r_cnt[i] >= w_len_m1))
                                 ? w_s[i] : r_filt[i];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_cnt[i] <= '0;
                end else if (w_s[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= w_len_m1) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    // Set wins over clear so a still-asserted channel survives a clear.
    assign w_latch_next = (r_latch & ~({NUM_CH{bus.i_intl_clr}} & ~w_f_next))
                        | (w_f_next & ~bus.i_bypass);

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_latch_next[i]) begin
                w_low_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt        <= '0;
            r_rise        <= '0;
            r_fall        <= '0;
            r_latch       <= '0;
            r_any         <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else begin
            r_filt  <= w_f_next;
            r_rise  <= w_f_next & ~r_filt;
            r_fall  <= ~w_f_next & r_filt;
            r_latch <= w_latch_next;
            r_any   <= |w_latch_next;
            if (bus.i_intl_clr) begin
                r_first_valid <= 1'b0;
                r_first_idx   <= '0;
            end else if (!r_first_valid && (w_latch_next != '0)) begin
                r_first_valid <= 1'b1;
                r_first_idx   <= w_low_idx;
            end
        end
    end

    assign bus.o_intl_ext    = r_filt;
    assign bus.o_rise_pulse  = r_rise;
    assign bus.o_fall_pulse  = r_fall;
    assign bus.o_intl_latch  = r_latch;
    assign bus.o_intl_any    = r_any;
    assign bus.o_first_valid = r_first_valid;
    assign bus.o_first_idx   = r_first_idx;

endmodule
`default_nettype wire

// File: doc/intl_ext_filter.md
Name: intl_ext_filter

Overview:
- Front-end conditioning stage for the 16 external interlock inputs; its outputs feed the interlock core's i_intl_ext bus.
- Per channel: synchronises the raw pin, applies polarity, debounces with a programmable stable-time, and emits rise/fall pulses.
- Keeps sticky per-channel fault latches and a first-fault index, so PS software can identify which external interlock tripped first.

Parameters:
NUM_CH, 16, number of external interlock channels
CNT_WIDTH, 16, width of the debounce counter and of i_filt_len
IDX_WIDTH, 4, width of the first-fault index (must be >= clog2(NUM_CH))

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, synchronous, active-high
i_intl_ext_raw  input  NUM_CH  raw external interlock pins (asynchronous)
i_polarity  input  NUM_CH  per channel: 1 = pin is active-low (inverted), 0 = active-high
i_bypass  input  NUM_CH  per channel: 1 = excluded from latches and first-fault
i_filt_len  input  CNT_WIDTH  required stable cycles N; value 0 is treated as 1
i_intl_clr  input  1  interlock clear, single-cycle pulse
o_intl_ext  output  NUM_CH  debounced level, active-high asserted, not masked
o_rise_pulse  output  NUM_CH  1-cycle pulse when o_intl_ext bit goes 0->1
o_fall_pulse  output  NUM_CH  1-cycle pulse when o_intl_ext bit goes 1->0
o_intl_latch  output  NUM_CH  sticky fault per channel
o_intl_any  output  1  OR of o_intl_latch
o_first_valid  output  1  first-fault index valid
o_first_idx  output  IDX_WIDTH  lowest-indexed channel of the first latch event

Behaviour:
- Reset:
  - Synchroniser FFs (2 stages) load i_polarity, so the polarised level s = ff2 ^ i_polarity = 0 after reset.
  - Filtered state, counters, pulses, latches, o_first_valid, o_first_idx, o_intl_any all reset to 0.
  - Reset mid-count discards any partial count.
- Debounce, per channel (N = max(i_filt_len,1)):
  - If s == f: cnt <= 0.
  - Else if cnt >= N-1: f <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - The >= compare covers i_filt_len being lowered mid-count: f updates on the next mismatch cycle.
- Latency: raw stable from sampling edge E0 -> o_intl_ext changes at edge E0+N+1. Any s glitch shorter than N cycles produces no change.
- Pulses: o_rise_pulse[i] = f_new & ~f_old, o_fall_pulse[i] = ~f_new & f_old, registered in the same edge as f, high exactly 1 cycle.
- Latch, per channel: next = (latch & ~(i_intl_clr & ~f_new)) | (f_new & ~i_bypass).
  - Set has priority over clear: a channel still asserted stays latched through a clear.
  - Setting i_bypass does not clear an existing latch; only i_intl_clr does.
- First fault:
  - i_intl_clr: o_first_valid <= 0, o_first_idx <= 0.
  - Else if !o_first_valid and latch_next != 0: capture the lowest set index of latch_next and set o_first_valid.
  - Once valid, the index holds until a clear. Simultaneous first rises pick the lowest index.
  - After a clear with channels still latched, recapture happens on the following cycle.
- o_intl_any is registered from latch_next (same cycle as o_intl_latch).
- Counter arithmetic is unsigned CNT_WIDTH; cnt never exceeds N-1, so there is no wrap.

Test Plan:
- Reset, i_polarity=16'h00F0, raw=16'h00F0 idle, hold 100 cycles -> o_intl_ext=0, all latches 0, no pulses.
- i_filt_len=10, ch3 raw 0->1 at E0 -> o_intl_ext[3]=1 at E0+11, o_rise_pulse[3] high one cycle, o_intl_latch[3]=1, o_first_valid=1, o_first_idx=3.
- i_filt_len=10, ch5 raw high 9 cycles, then 1-cycle low, then high 10 cycles -> no change until the 10-cycle run completes; a 9-cycle pulse never asserts.
- ch7 and ch2 raw rise on the same edge -> o_first_idx=2. A later rise of ch0 does not change the index.
- ch4 asserted, i_intl_clr pulse while ch4 still high -> latch[4] stays 1. o_first_valid drops for 1 cycle, then recaptures idx 4. After ch4 deasserts, a second clear clears latch[4] and o_intl_any.
- i_bypass[6]=1, ch6 asserts -> o_intl_ext[6]=1 and o_rise_pulse[6] fires, but latch[6]=0 and o_first_valid stays 0.
- i_filt_len=0 -> behaves as N=1: output follows at E0+2.
